// File: rtl/perceptron_train_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_train_ctrl
//  Purpose  : Training sequencer for a 2-input perceptron neuron. Holds a
//             small sample table plus the weight/bias registers, presents
//             each sample to the neuron, captures its output after a fixed
//             latency and applies the perceptron learning rule. Epochs
//             repeat until an error-free epoch or the epoch limit is reached.
//  Ports    : clk, reset_n            - clock, async active-low reset
//             wr_en/wr_addr/wr_data   - sample table write {target,x2,x1}
//             n_last                  - index of last valid sample (on start)
//             start, abort            - run control (abort has priority)
//             p_x1/p_x2/p_w1/p_w2/p_bias, p_y - neuron interface
//             busy, done, converged, epoch_cnt, err_cnt - status
//  Config   : PTRAIN_SAT_EN - when defined, weight updates saturate instead
//             of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module perceptron_train_ctrl #(
    parameter int NUM_SAMPLES = 8,
    parameter int LATENCY     = 2,
    parameter int MAX_EPOCHS  = 15,
    parameter int W_WIDTH     = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SAMPLES)-1:0] wr_addr,
    input  logic [8:0]                     wr_data,
    input  logic [$clog2(NUM_SAMPLES)-1:0] n_last,
    input  logic                           start,
    input  logic                           abort,
    output logic [3:0]                     p_x1,
    output logic [3:0]                     p_x2,
    output logic signed [W_WIDTH-1:0]      p_w1,
    output logic signed [W_WIDTH-1:0]      p_w2,
    output logic signed [W_WIDTH-1:0]      p_bias,
    input  logic                           p_y,
    output logic                           busy,
    output logic                           done,
    output logic                           converged,
    output logic [7:0]                     epoch_cnt,
    output logic [4:0]                     err_cnt
);

    localparam int c_idx_w = $clog2(NUM_SAMPLES);
    localparam int c_lat_w = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    localparam logic signed [W_WIDTH:0] c_one = {{W_WIDTH{1'b0}}, 1'b1};
`ifdef PTRAIN_SAT_EN
    localparam logic signed [W_WIDTH:0] c_w_max = {2'b00, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH:0] c_w_min = {2'b11, {(W_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_APPLY     = 3'd1,
        S_UPDATE    = 3'd2,
        S_EPOCH_END = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [8:0]                 r_table [NUM_SAMPLES];
    logic [c_idx_w-1:0]         r_idx;
    logic [c_idx_w-1:0]         r_n_last;
    logic [c_lat_w-1:0]         r_lat;
    logic                       r_target;
    logic                       r_y;
    logic signed [W_WIDTH-1:0]  r_w1;
    logic signed [W_WIDTH-1:0]  r_w2;
    logic signed [W_WIDTH-1:0]  r_bias;
    logic [7:0]                 r_epoch;
    logic [4:0]                 r_err;
    logic                       r_conv;
    logic [3:0]                 r_x1;
    logic [3:0]                 r_x2;

    logic                       w_wr_ok;
    logic                       w_lat_last;
    logic                       w_last_sample;
    logic                       w_epoch_limit;
    logic                       w_err;
    logic [c_idx_w-1:0]         w_next_idx;
    logic [8:0]                 w_entry;
    logic signed [W_WIDTH:0]    w_x1_ext;
    logic signed [W_WIDTH:0]    w_x2_ext;
    logic signed [W_WIDTH:0]    w_d1;
    logic signed [W_WIDTH:0]    w_d2;
    logic signed [W_WIDTH:0]    w_db;

    // Sum is formed one bit wider than the weight so the overflow is visible
    // before it is either clamped or dropped.
    function automatic logic signed [W_WIDTH-1:0] f_update(
        input logic signed [W_WIDTH-1:0] w,
        input logic signed [W_WIDTH:0]   d
    );
        logic signed [W_WIDTH:0] sum;
        sum = $signed({w[W_WIDTH-1], w}) + d;
`ifdef PTRAIN_SAT_EN
        if (sum > c_w_max) begin
            return c_w_max[W_WIDTH-1:0];
        end else if (sum < c_w_min) begin
            return c_w_min[W_WIDTH-1:0];
        end else begin
            return sum[W_WIDTH-1:0];
        end
`else
        return sum[W_WIDTH-1:0];
`endif
    endfunction

    // ------------------------------------------------------------------
    // Sample table (not reset); writable only while not training
    // ------------------------------------------------------------------
    assign w_wr_ok = wr_en && !abort && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Index of the sample loaded on the next entry into APPLY. A write in
    // the same cycle as start is forwarded so training sees the new entry.
    assign w_next_idx = (r_state == S_UPDATE) ? r_idx + 1'b1 : '0;
    assign w_entry    = (w_wr_ok && (wr_addr == w_next_idx)) ? wr_data
                                                              : r_table[w_next_idx];

    assign w_lat_last    = (r_lat == c_lat_w'(LATENCY));
    assign w_last_sample = (r_idx == r_n_last);
    assign w_epoch_limit = ((r_epoch + 8'd1) == 8'(MAX_EPOCHS));
    assign w_err         = r_target ^ r_y;

    // err*x with err in {-1,+1}; x is zero-extended unsigned
    assign w_x1_ext = {{(W_WIDTH-3){1'b0}}, r_x1};
    assign w_x2_ext = {{(W_WIDTH-3){1'b0}}, r_x2};
    assign w_d1     = r_target ? w_x1_ext : -w_x1_ext;
    assign w_d2     = r_target ? w_x2_ext : -w_x2_ext;
    assign w_db     = r_target ? c_one    : -c_one;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) w_state_nxt = S_APPLY;
                end
                S_APPLY: begin
                    if (w_lat_last) w_state_nxt = S_UPDATE;
                end
                S_UPDATE: begin
                    w_state_nxt = w_last_sample ? S_EPOCH_END : S_APPLY;
                end
                S_EPOCH_END: begin
                    w_state_nxt = ((r_err == 5'd0) || w_epoch_limit) ? S_DONE : S_APPLY;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_n_last <= '0;
            r_lat    <= '0;
            r_target <= 1'b0;
            r_y      <= 1'b0;
            r_w1     <= '0;
            r_w2     <= '0;
            r_bias   <= '0;
            r_epoch  <= '0;
            r_err    <= '0;
            r_conv   <= 1'b0;
            r_x1     <= '0;
            r_x2     <= '0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_w1     <= '0;
                        r_w2     <= '0;
                        r_bias   <= '0;
                        r_epoch  <= '0;
                        r_err    <= '0;
                        r_conv   <= 1'b0;
                        r_n_last <= n_last;
                        r_idx    <= '0;
                        r_lat    <= '0;
                        r_x1     <= w_entry[3:0];
                        r_x2     <= w_entry[7:4];
                        r_target <= w_entry[8];
                    end
                end
                S_APPLY: begin
                    if (w_lat_last) begin
                        r_y   <= p_y;
                        r_lat <= '0;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (w_err) begin
                        r_w1   <= f_update(r_w1, w_d1);
                        r_w2   <= f_update(r_w2, w_d2);
                        r_bias <= f_update(r_bias, w_db);
                        r_err  <= r_err + 5'd1;
                    end
                    if (!w_last_sample) begin
                        r_idx    <= w_next_idx;
                        r_x1     <= w_entry[3:0];
                        r_x2     <= w_entry[7:4];
                        r_target <= w_entry[8];
                    end
                end
                S_EPOCH_END: begin
                    r_epoch <= r_epoch + 8'd1;
                    if (r_err == 5'd0) begin
                        r_conv <= 1'b1;
                    end else if (!w_epoch_limit) begin
                        r_err    <= '0;
                        r_idx    <= '0;
                        r_x1     <= w_entry[3:0];
                        r_x2     <= w_entry[7:4];
                        r_target <= w_entry[8];
                    end
                end
                default: ;
            endcase
        end
    end

    assign p_x1      = r_x1;
    assign p_x2      = r_x2;
    assign p_w1      = r_w1;
    assign p_w2      = r_w2;
    assign p_bias    = r_bias;
    assign busy      = (r_state == S_APPLY) || (r_state == S_UPDATE) || (r_state == S_EPOCH_END);
    assign done      = (r_state == S_DONE);
    assign converged = r_conv;
    assign epoch_cnt = r_epoch;
    assign err_cnt   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_train_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perceptron_train_ctrl
//  Purpose  : Self-checking bench for perceptron_train_ctrl. A behavioural
//             neuron with two cycles of latency answers the DUT; a training
//             model predicts per-epoch weights and the final status, which
//             are queued and compared as the DUT reports each epoch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_train_ctrl;

    localparam int LAT = 2;
`ifdef PTRAIN_SAT_EN
    localparam int c_w1_ep9   = 127;
    localparam int c_w1_final = 127;
`else
    localparam int c_w1_ep9   = -121;
    localparam int c_w1_final = -31;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_addr = '0;
    logic [8:0]        wr_data = '0;
    logic [2:0]        n_last = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        p_x1, p_x2;
    logic signed [7:0] p_w1, p_w2, p_bias;
    logic              p_y;
    logic              busy, done, converged;
    logic [7:0]        epoch_cnt;
    logic [4:0]        err_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct { int ep; int w1; int w2; int b; } ep_rec_t;
    typedef struct { int ep; int errs; int conv; } fin_rec_t;
    ep_rec_t  ep_q[$];
    fin_rec_t fin_q[$];

    logic [8:0] tb_tab [16];
    bit         force_y = 1'b0;
    bit         sat_chk = 1'b0;
    int         exp_len = 0;
    int         last_ep_cyc = 0;
    int         cyc = 0;
    logic [7:0] prev_ep = '0;
    logic       prev_done = 1'b0;

    perceptron_train_ctrl #(
        .NUM_SAMPLES(8), .LATENCY(LAT), .MAX_EPOCHS(15), .W_WIDTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .n_last(n_last), .start(start), .abort(abort),
        .p_x1(p_x1), .p_x2(p_x2), .p_w1(p_w1), .p_w2(p_w2), .p_bias(p_bias),
        .p_y(p_y), .busy(busy), .done(done), .converged(converged),
        .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural neuron: threshold unit followed by a 2-stage pipeline
    logic s1 = 1'b0, s2 = 1'b0;
    always @(posedge clk) begin
        s1 <= force_y ? 1'b0
                      : ((int'(p_w1) * int'(p_x1) + int'(p_w2) * int'(p_x2) + int'(p_bias)) > 0);
        s2 <= s1;
    end
    assign p_y = s2;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input int x1, input int x2, input int t);
        return {t[0], x2[3:0], x1[3:0]};
    endfunction

    function automatic int upd(input int w, input int d);
        int s;
        s = w + d;
`ifdef PTRAIN_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`else
        s = ((s + 128) & 255) - 128;
`endif
        return s;
    endfunction

    // Predict the whole run and queue per-epoch and final expectations
    task automatic push_model(input int nl, input bit frc);
        int w1, w2, b, errs, ep, x1, x2, t, y, e;
        bit conv;
        w1 = 0; w2 = 0; b = 0; ep = 0; conv = 1'b0; errs = 0;
        while (1) begin
            ep++;
            errs = 0;
            for (int i = 0; i <= nl; i++) begin
                x1 = int'(tb_tab[i][3:0]);
                x2 = int'(tb_tab[i][7:4]);
                t  = int'(tb_tab[i][8]);
                y  = frc ? 0 : (((w1 * x1 + w2 * x2 + b) > 0) ? 1 : 0);
                if (t != y) begin
                    e  = (t == 1) ? 1 : -1;
                    w1 = upd(w1, e * x1);
                    w2 = upd(w2, e * x2);
                    b  = upd(b, e);
                    errs++;
                end
            end
            ep_q.push_back('{ep, w1, w2, b});
            if (errs == 0) begin
                conv = 1'b1;
                break;
            end
            if (ep == 15) break;
        end
        fin_q.push_back('{ep, errs, int'(conv)});
    endtask

    // Scoreboard consumer: one record per completed epoch, one per finish
    always @(negedge clk) begin : mon
        ep_rec_t  e;
        fin_rec_t f;
        cyc++;
        if (epoch_cnt != prev_ep && epoch_cnt != 8'd0) begin
            if (ep_q.size() == 0) begin
                check("ep_queue_empty", 1, 0);
            end else begin
                e = ep_q.pop_front();
                check("epoch_num", int'(epoch_cnt), e.ep);
                check("epoch_w1", int'(p_w1), e.w1);
                check("epoch_w2", int'(p_w2), e.w2);
                check("epoch_bias", int'(p_bias), e.b);
            end
            if (last_ep_cyc != 0) check("epoch_len", cyc - last_ep_cyc, exp_len);
            last_ep_cyc = cyc;
            if (sat_chk && epoch_cnt == 8'd9) check("sat_w1_ep9", int'(p_w1), c_w1_ep9);
        end
        if (done && !prev_done) begin
            if (fin_q.size() == 0) begin
                check("fin_queue_empty", 1, 0);
            end else begin
                f = fin_q.pop_front();
                check("fin_converged", int'(converged), f.conv);
                check("fin_epoch_cnt", int'(epoch_cnt), f.ep);
                check("fin_err_cnt", int'(err_cnt), f.errs);
            end
        end
        prev_ep   = epoch_cnt;
        prev_done = done;
    end

    task automatic wr_entry(input int a, input logic [8:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        tb_tab[a] = d;
    endtask

    task automatic do_run(input int nl, input bit frc, input bit wr0,
                          input logic [8:0] d0, input bit poke);
        int n;
        if (wr0) tb_tab[0] = d0;
        push_model(nl, frc);
        exp_len     = (nl + 1) * (LAT + 2) + 1;
        last_ep_cyc = 0;
        force_y     = frc;
        @(negedge clk);
        start = 1'b1; n_last = 3'(nl);
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = d0;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_after_start", int'(done), 0);
        if (poke) begin
            repeat (6) @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 9'h1FF; start = 1'b1;
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
            check("busy_after_poke", int'(busy), 1);
        end
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("run_done", int'(done), 1);
        @(negedge clk);
        check("ep_q_left", ep_q.size(), 0);
        check("fin_q_left", fin_q.size(), 0);
        ep_q.delete();
        fin_q.delete();
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_conv", int'(converged), 0);
        check("rst_epoch", int'(epoch_cnt), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_w1", int'(p_w1), 0);
        check("rst_w2", int'(p_w2), 0);
        check("rst_bias", int'(p_bias), 0);
        check("rst_x1", int'(p_x1), 0);
        check("rst_x2", int'(p_x2), 0);
        reset_n = 1'b1;

        // AND with 0/15 inputs
        wr_entry(0, mk(0, 0, 0));
        wr_entry(1, mk(0, 15, 0));
        wr_entry(2, mk(15, 0, 0));
        wr_entry(3, mk(15, 15, 1));
        do_run(3, 1'b0, 1'b0, '0, 1'b0);

        // Saturation / wrap with neuron output forced low
        wr_entry(0, mk(15, 15, 1));
        sat_chk = 1'b1;
        do_run(0, 1'b1, 1'b0, '0, 1'b0);
        sat_chk = 1'b0;
        check("sat_conv", int'(converged), 0);
        check("sat_epoch", int'(epoch_cnt), 15);
        check("sat_err", int'(err_cnt), 1);
        check("sat_w1_final", int'(p_w1), c_w1_final);

        // AND with 0/1 inputs: entry 0 written together with start, and a
        // write + start attempted mid-run
        wr_entry(1, mk(0, 1, 0));
        wr_entry(2, mk(1, 0, 0));
        wr_entry(3, mk(1, 1, 1));
        do_run(3, 1'b0, 1'b1, mk(0, 0, 0), 1'b1);
        check("and01_conv", int'(converged), 1);
        check("and01_epochs", int'(epoch_cnt), 6);
        for (int i = 0; i < 4; i++) begin
            s = int'(p_w1) * int'(tb_tab[i][3:0]) + int'(p_w2) * int'(tb_tab[i][7:4]) + int'(p_bias);
            check("and01_class", (s > 0) ? 1 : 0, int'(tb_tab[i][8]));
        end
        // Rerun from DONE: table[0] must still be the pre-poke entry
        do_run(3, 1'b0, 1'b0, '0, 1'b0);

        // Abort during the third APPLY of epoch 1
        wr_entry(0, mk(3, 5, 1));
        wr_entry(1, mk(2, 7, 0));
        wr_entry(2, mk(4, 1, 0));
        wr_entry(3, mk(6, 6, 1));
        force_y = 1'b0;
        @(negedge clk);
        start = 1'b1; n_last = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_px1_third", int'(p_x1), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_w1", int'(p_w1), 1);
        check("abort_w2", int'(p_w2), -2);
        check("abort_bias", int'(p_bias), 0);
        check("abort_err", int'(err_cnt), 2);
        check("abort_epoch", int'(epoch_cnt), 0);

        // Asynchronous reset in the middle of the second UPDATE
        @(negedge clk);
        start = 1'b1; n_last = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_w1", int'(p_w1), 3);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_w1", int'(p_w1), 0);
        check("arst_bias", int'(p_bias), 0);
        check("arst_x1", int'(p_x1), 0);
        check("arst_err", int'(err_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_run(3, 1'b0, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perceptron_train_ctrl.md
Name: perceptron_train_ctrl

Overview:
Training sequencer for the 2-input perceptron neuron. It holds a small sample table and weight/bias registers, and drives each sample into the neuron. After a fixed latency it captures the neuron output and applies the perceptron learning rule. Epochs repeat until one epoch has zero errors or an epoch limit is reached. It sits beside the perceptron instance inside the top-level tile and owns its weights.

Parameters:
- NUM_SAMPLES, 8, sample table depth (power of 2, max 16).
- LATENCY, 2, cycles from driving p_x1/p_x2 to p_y being valid (>=0).
- MAX_EPOCHS, 15, epoch limit (1..255).
- W_WIDTH, 8, signed width of w1, w2 and bias.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  sample table write strobe; honoured in IDLE/DONE only
- wr_addr  in  $clog2(NUM_SAMPLES)  sample index
- wr_data  in  9  {target, x2[3:0], x1[3:0]}
- n_last  in  $clog2(NUM_SAMPLES)  index of last valid sample; sampled on start
- start  in  1  begin training; 1-cycle pulse
- abort  in  1  stop training
- p_x1  out  4  neuron input 1
- p_x2  out  4  neuron input 2
- p_w1  out  W_WIDTH  signed weight 1
- p_w2  out  W_WIDTH  signed weight 2
- p_bias  out  W_WIDTH  signed bias
- p_y  in  1  neuron output
- busy  out  1  training in progress
- done  out  1  training finished; held
- converged  out  1  final epoch had zero errors
- epoch_cnt  out  8  completed epochs
- err_cnt  out  5  misclassifications in the current or final epoch

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, weights 0. The sample table is not reset.
- States: IDLE, APPLY, UPDATE, EPOCH_END, DONE.
- IDLE/DONE with start=1:
  - clears w1, w2, bias, epoch_cnt, err_cnt, done, converged;
  - latches n_last; sets idx=0;
  - goes to APPLY next cycle; busy=1.
- APPLY:
  - p_x1/p_x2 = table[idx] x fields, registered.
  - lat_cnt counts 0..LATENCY, so APPLY lasts LATENCY+1 cycles.
  - On the last cycle, p_y is captured and the state goes to UPDATE.
- UPDATE (1 cycle):
  - err = target - y_captured, in {-1, 0, +1}.
  - If err != 0: w1 += err*x1, w2 += err*x2, bias += err; err_cnt += 1.
  - Weights are updated in the same cycle.
  - If idx == n_last, go to EPOCH_END; otherwise idx+1 and APPLY.
- EPOCH_END (1 cycle): epoch_cnt += 1.
  - If err_cnt == 0: go to DONE with converged=1.
  - Else if epoch_cnt+1 == MAX_EPOCHS: go to DONE with converged=0.
  - Otherwise clear err_cnt, set idx=0, go to APPLY.
- DONE: busy=0, done=1. Weights, epoch_cnt, err_cnt and converged hold until the next start or reset.
- Cycles per epoch = (n_last+1)*(LATENCY+2) + 1.
- abort has priority over all other inputs.
  - Any state goes to IDLE next cycle; busy=0, done=0.
  - Weights and counters hold.
- start while busy: ignored. wr_en while busy: ignored, table unchanged.
- Simultaneous wr_en and start in IDLE: the write completes, and training uses the new entry.
- x values are unsigned 0..15 and are zero-extended before weight arithmetic.
- Weight update overflow is handled per PTRAIN_SAT_EN.

Optional Feature:
PTRAIN_SAT_EN
- Defined: each updated w1/w2/bias is clamped to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1]. The clamp is computed at W_WIDTH+1 bits.
- Undefined: plain two's-complement wrap at W_WIDTH bits.

Test Plan:
- AND training. Table = (0,0,0), (0,15,0), (15,0,0), (15,15,1); n_last=3. Bench neuron: y = (w1*x1+w2*x2+bias > 0), LATENCY=2.
  -> done=1, converged=1, epoch_cnt <= 15. Final weights classify all 4 samples correctly.
  -> Epoch length exactly 17 cycles.
- Saturation. One sample (15,15,1), n_last=0, bench forces p_y=0.
  -> w1 = 15, 30, ... 120, then 127 after epoch 9 with PTRAIN_SAT_EN; -121 without it.
  -> done with converged=0, epoch_cnt=15, err_cnt=1.
- Abort. abort pulse during the third APPLY of epoch 1.
  -> IDLE next cycle; busy=0, done=0; weights equal the post-second-UPDATE values.
- Busy protection. wr_en to addr 0 and start pulse while busy.
  -> table[0] unchanged (read back via next run), training continues undisturbed.
- Async reset mid-UPDATE. reset_n low between clock edges.
  -> all outputs 0 immediately. After release, start retrains using the preserved table.
